// File: rtl/pca_pwm_engine.sv
// PCA9685-style PWM core: prescaled 12-bit period counter, 16 compare channels.
// Channel parameters are shadowed on wrap (or continuously in sleep) to avoid glitches.
module pca_pwm_engine #(
  parameter int NUM_CHANNELS = 16,
  parameter int PRESCALE_MIN = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [0:NUM_CHANNELS*32-1]   register_led_i,
  input  logic [7:0]                   prescale_i,
  input  logic                         tick_i,
  input  logic                         sleep_i,
  input  logic                         invrt_i,
  output logic [NUM_CHANNELS-1:0]      pwm_o,
  output logic [11:0]                  count_o,
  output logic                         period_start_o
);

  logic [7:0]              r_pre;
  logic [11:0]             r_cnt;
  logic                    r_ps;
  logic [NUM_CHANNELS-1:0] r_pwm;

  logic [11:0] r_on   [NUM_CHANNELS];
  logic [11:0] r_off  [NUM_CHANNELS];
  logic        r_fon  [NUM_CHANNELS];
  logic        r_foff [NUM_CHANNELS];

  logic [11:0] w_on   [NUM_CHANNELS];
  logic [11:0] w_off  [NUM_CHANNELS];
  logic        w_fon  [NUM_CHANNELS];
  logic        w_foff [NUM_CHANNELS];

  logic [7:0]              w_eff_pre;
  logic                    w_pre_hit;
  logic                    w_wrap;
  logic                    w_load;
  logic [NUM_CHANNELS-1:0] w_raw;

  assign w_eff_pre = (prescale_i < 8'(PRESCALE_MIN)) ?
                     8'(PRESCALE_MIN) : prescale_i;
  // >= keeps the prescaler from running the long way round
  // if PRE_SCALE is lowered below the current prescaler value
  assign w_pre_hit = tick_i && (r_pre >= w_eff_pre);
  assign w_wrap    = w_pre_hit && (r_cnt == 12'hFFF);
  assign w_load    = sleep_i || w_wrap;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_on[i]   = {register_led_i[32*i+12 +: 4],
                   register_led_i[32*i +: 8]};
      w_fon[i]  = register_led_i[32*i+11];
      w_off[i]  = {register_led_i[32*i+28 +: 4],
                   register_led_i[32*i+16 +: 8]};
      w_foff[i] = register_led_i[32*i+27];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else if (sleep_i) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else begin
      r_ps <= w_wrap;
      if (w_pre_hit) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 12'd1;
      end else if (tick_i) begin
        r_pre <= r_pre + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_on[i]   <= '0;
        r_off[i]  <= '0;
        r_fon[i]  <= 1'b0;
        r_foff[i] <= 1'b0;
      end
    end else if (w_load) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_on[i]   <= w_on[i];
        r_off[i]  <= w_off[i];
        r_fon[i]  <= w_fon[i];
        r_foff[i] <= w_foff[i];
      end
    end
  end

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_foff[i])
        w_raw[i] = 1'b0;
      else if (r_fon[i])
        w_raw[i] = 1'b1;
      else if (r_on[i] == r_off[i])
        w_raw[i] = 1'b0;
      else if (r_on[i] < r_off[i])
        w_raw[i] = (r_cnt >= r_on[i]) && (r_cnt < r_off[i]);
      else
        w_raw[i] = (r_cnt >= r_on[i]) || (r_cnt < r_off[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_pwm <= {NUM_CHANNELS{invrt_i}};
    else if (sleep_i)
      r_pwm <= {NUM_CHANNELS{invrt_i}};
    else
      r_pwm <= w_raw ^ {NUM_CHANNELS{invrt_i}};
  end

  assign pwm_o          = r_pwm;
  assign count_o        = r_cnt;
  assign period_start_o = r_ps;

endmodule

// File: tb/tb_pca_pwm_engine.sv
// Bench for pca_pwm_engine: randomized parameters checked against a
// tick-count based model of the period counter and channel compare rules.
module tb_pca_pwm_engine;
  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic [0:N*32-1]  led = '0;
  logic [7:0]       prescale_i = 8'd3;
  logic             tick_i = 1'b0;
  logic             sleep_i = 1'b0;
  logic             invrt_i = 1'b0;
  logic [N-1:0]     pwm_o;
  logic [11:0]      count_o;
  logic             period_start_o;

  pca_pwm_engine #(.NUM_CHANNELS(N), .PRESCALE_MIN(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .register_led_i(led),
    .prescale_i(prescale_i), .tick_i(tick_i), .sleep_i(sleep_i),
    .invrt_i(invrt_i), .pwm_o(pwm_o), .count_o(count_o),
    .period_start_o(period_start_o));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int p_on [N];
  int p_off [N];
  bit p_fon [N];
  bit p_foff [N];
  int s_on [N];
  int s_off [N];
  bit s_fon [N];
  bit s_foff [N];
  int m_ticks = 0;
  logic [N-1:0] e_pwm = '0;
  logic e_ps = 1'b0;
  int hi0 = 0;

  function automatic int eff();
    return (int'(prescale_i) < 3) ? 3 : int'(prescale_i);
  endfunction

  function automatic int m_cnt();
    return (m_ticks / (eff() + 1)) % 4096;
  endfunction

  function automatic bit raw(input int c, input int n);
    if (s_foff[n]) return 1'b0;
    if (s_fon[n]) return 1'b1;
    if (s_on[n] == s_off[n]) return 1'b0;
    if (s_on[n] < s_off[n]) return (c >= s_on[n]) && (c < s_off[n]);
    return (c >= s_on[n]) || (c < s_off[n]);
  endfunction

  task automatic set_ch(input int n, input int on, input int off,
                        input bit fon, input bit foff);
    logic [11:0] a;
    logic [11:0] b;
    a = 12'(on);
    b = 12'(off);
    p_on[n] = int'(a);
    p_off[n] = int'(b);
    p_fon[n] = fon;
    p_foff[n] = foff;
    led[32*n +: 8]    = a[7:0];
    led[32*n+8 +: 8]  = {3'($urandom), fon, a[11:8]};
    led[32*n+16 +: 8] = b[7:0];
    led[32*n+24 +: 8] = {3'($urandom), foff, b[11:8]};
  endtask

  task automatic rand_all();
    for (int n = 0; n < N; n++)
      set_ch(n, $urandom_range(0, 4095), $urandom_range(0, 4095),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endtask

  task automatic load_shadow();
    for (int n = 0; n < N; n++) begin
      s_on[n] = p_on[n];
      s_off[n] = p_off[n];
      s_fon[n] = p_fon[n];
      s_foff[n] = p_foff[n];
    end
  endtask

  task automatic model_reset(input bit inv);
    m_ticks = 0;
    for (int n = 0; n < N; n++) begin
      s_on[n] = 0;
      s_off[n] = 0;
      s_fon[n] = 1'b0;
      s_foff[n] = 1'b0;
    end
    e_pwm = {N{inv}};
    e_ps = 1'b0;
  endtask

  task automatic step();
    int c;
    @(posedge clk);
    e_ps = 1'b0;
    if (sleep_i) begin
      e_pwm = {N{invrt_i}};
      m_ticks = 0;
      load_shadow();
    end else begin
      c = m_cnt();
      for (int n = 0; n < N; n++) e_pwm[n] = raw(c, n) ^ invrt_i;
      if (tick_i) begin
        m_ticks++;
        if (m_ticks % ((eff() + 1) * 4096) == 0) begin
          e_ps = 1'b1;
          load_shadow();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b1;
      tick_i = 1'b1;
      sleep_i = 1'b0;
      invrt_i = (k == 1);
      prescale_i = 8'($urandom_range(0, 6));
      rand_all();
      rst_i = 1'b1;
      #2;
      checks++;
      if (count_o !== 12'd0) begin
        failures++;
        $display("FAIL reset_cnt got=%0d exp=0", count_o);
      end
      checks++;
      if (pwm_o !== {N{invrt_i}}) begin
        failures++;
        $display("FAIL reset_pwm got=%h exp=%h", pwm_o, {N{invrt_i}});
      end
      checks++;
      if (period_start_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_ps got=%b exp=0", period_start_o);
      end
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      model_reset(invrt_i);
      for (int i = 0; i < 60; i++) begin
        step();
        if (ok) begin
          checks++;
          if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
              period_start_o !== e_ps) begin
            failures++;
            ok = 1'b0;
            $display("FAIL reset_run pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                     pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
          end
        end
      end
    end
  endtask

  task automatic test_duty50();
    bit ok = 1'b1;
    invrt_i = 1'b0;
    tick_i = 1'b1;
    prescale_i = 8'd3;
    rand_all();
    set_ch(0, 12'h000, 12'h800, 1'b0, 1'b0);
    sleep_i = 1'b1;
    step();
    step();
    sleep_i = 1'b0;
    hi0 = 0;
    for (int i = 1; i <= 4000; i++) begin
      step();
      if (pwm_o[0] === 1'b1) hi0++;
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL duty50 pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (count_o !== 12'd1000 || hi0 != 4000) begin
      failures++;
      $display("FAIL duty50_early cnt=%0d exp=1000 hi=%0d exp=4000",
               count_o, hi0);
    end
  endtask

  task automatic test_mid_update();
    bit ok = 1'b1;
    int pulses = 0;
    int hi = 0;
    int fall = -1;
    bit prev;
    set_ch(0, 12'h000, 12'h400, 1'b0, 1'b0);
    prev = pwm_o[0];
    for (int i = 4001; i <= 16384; i++) begin
      step();
      if (pwm_o[0] === 1'b1) hi0++;
      if (period_start_o === 1'b1) pulses++;
      if (prev && pwm_o[0] === 1'b0 && fall < 0) fall = int'(count_o);
      prev = pwm_o[0];
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL mid_upd pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (hi0 != 8192 || fall != 12'h800) begin
      failures++;
      $display("FAIL period1 hi=%0d exp=8192 fall_cnt=%0d exp=2048", hi0, fall);
    end
    checks++;
    if (period_start_o !== 1'b1 || pulses != 1 || count_o !== 12'd0) begin
      failures++;
      $display("FAIL wrap1 ps=%b pulses=%0d cnt=%0d exp 1/1/0",
               period_start_o, pulses, count_o);
    end
    fall = -1;
    prev = pwm_o[0];
    for (int i = 0; i < 4400; i++) begin
      step();
      if (pwm_o[0] === 1'b1) hi++;
      if (prev && pwm_o[0] === 1'b0 && fall < 0) fall = int'(count_o);
      prev = pwm_o[0];
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL mid_upd2 pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (hi != 4096 || fall != 12'h400) begin
      failures++;
      $display("FAIL period2 hi=%0d exp=4096 fall_cnt=%0d exp=1024", hi, fall);
    end
  endtask

  task automatic test_wrap_clamp();
    bit ok = 1'b1;
    bit upd = 1'b0;
    int hi1 = 0;
    int lo2 = 0;
    invrt_i = 1'b0;
    prescale_i = 8'($urandom_range(0, 2));
    rand_all();
    set_ch(1, 4000, 100, 1'b0, 1'b0);
    set_ch(2, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1, 1'b0);
    sleep_i = 1'b1;
    step();
    step();
    sleep_i = 1'b0;
    for (int i = 1; i <= 16384; i++) begin
      step();
      if (pwm_o[1] === 1'b1) hi1++;
      if (pwm_o[2] !== 1'b1) lo2++;
      if (!upd && m_cnt() == 2000) begin
        set_ch(2, 12'h123, 12'h456, 1'b1, 1'b1);
        upd = 1'b1;
      end
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL clamp pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (hi1 != 784) begin
      failures++;
      $display("FAIL wrap_pulse hi=%0d exp=784", hi1);
    end
    checks++;
    if (lo2 != 0) begin
      failures++;
      $display("FAIL full_on low_cycles=%0d exp=0", lo2);
    end
    checks++;
    if (period_start_o !== 1'b1) begin
      failures++;
      $display("FAIL clamp_period ps=%b exp=1", period_start_o);
    end
  endtask

  task automatic test_full_off();
    bit ok = 1'b1;
    int hi2 = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pwm_o[2] !== 1'b0) hi2++;
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL full_off pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (hi2 != 0) begin
      failures++;
      $display("FAIL full_priority high_cycles=%0d exp=0", hi2);
    end
  endtask

  task automatic test_sleep_invert();
    bit ok = 1'b1;
    int guard = 0;
    int bad = 0;
    int ps_seen = 0;
    while (m_cnt() != 2000 && guard < 9000) begin
      step();
      guard++;
    end
    checks++;
    if (count_o !== 12'd2000) begin
      failures++;
      $display("FAIL sleep_reach cnt=%0d exp=2000", count_o);
    end
    invrt_i = 1'b1;
    sleep_i = 1'b1;
    set_ch(3, 12'h123, 12'h123, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (count_o !== 12'd0 || pwm_o !== 16'hFFFF ||
          period_start_o !== 1'b0) bad++;
      if (i == 10) rand_all();
    end
    set_ch(3, 12'h123, 12'h123, 1'b0, 1'b0);
    step();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sleep_hold bad_cycles=%0d exp=0 cnt=%0d pwm=%h",
               bad, count_o, pwm_o);
    end
    sleep_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (period_start_o === 1'b1) ps_seen++;
      if (pwm_o[3] !== 1'b1) bad++;
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL wake pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (ps_seen != 0 || bad != 0 || count_o !== 12'd50) begin
      failures++;
      $display("FAIL wake_restart ps=%0d bad=%0d cnt=%0d exp 0/0/50",
               ps_seen, bad, count_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b1;
    int guard = 0;
    int bad = 0;
    invrt_i = 1'b0;
    while (m_cnt() != 3000 && guard < 13000) begin
      step();
      guard++;
    end
    checks++;
    if (count_o !== 12'd3000) begin
      failures++;
      $display("FAIL rst_reach cnt=%0d exp=3000", count_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (count_o !== 12'd0 || pwm_o !== 16'h0000 || period_start_o !== 1'b0) begin
      failures++;
      $display("FAIL async_rst cnt=%0d pwm=%h ps=%b exp 0/0000/0",
               count_o, pwm_o, period_start_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset(1'b0);
    rand_all();
    for (int i = 0; i < 200; i++) begin
      step();
      if (pwm_o !== 16'h0000) bad++;
      if (ok) begin
        checks++;
        if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
            period_start_o !== e_ps) begin
          failures++;
          ok = 1'b0;
          $display("FAIL rst_run pwm=%h/%h cnt=%0d/%0d ps=%b/%b",
                   pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_zero_shadow bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_random();
    bit ok = 1'b1;
    for (int r = 0; r < 6; r++) begin
      sleep_i = 1'b1;
      prescale_i = 8'($urandom_range(0, 5));
      rand_all();
      step();
      step();
      sleep_i = 1'b0;
      for (int i = 0; i < 500; i++) begin
        tick_i = ($urandom_range(0, 3) != 0);
        invrt_i = ($urandom_range(0, 15) == 0) ? ~invrt_i : invrt_i;
        if ($urandom_range(0, 31) == 0)
          set_ch($urandom_range(0, N - 1), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), 1'b0, 1'b0);
        step();
        if (ok) begin
          checks++;
          if (pwm_o !== e_pwm || count_o !== 12'(m_cnt()) ||
              period_start_o !== e_ps) begin
            failures++;
            ok = 1'b0;
            $display("FAIL random r=%0d pwm=%h/%h cnt=%0d/%0d ps=%b/%b", r,
                     pwm_o, e_pwm, count_o, m_cnt(), period_start_o, e_ps);
          end
        end
      end
    end
    tick_i = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_duty50();
    test_mid_update();
    test_wrap_clamp();
    test_full_off();
    test_sleep_invert();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pca_pwm_engine.md
Name: pca_pwm_engine

Overview:
- Downstream consumer of the atomically updated LED/PWM parameter bus produced by the register store.
- Emulates the PCA9685 PWM core. It runs a prescaled 12-bit period counter (0..4095) and drives 16 PWM outputs from per-channel ON/OFF compare values, including full-on/full-off, sleep and output inversion.
- Per-channel parameters are shadowed at period start, so outputs never glitch mid-period.

Parameters:
- NUM_CHANNELS, 16, number of PWM channels; the register_led_i width is NUM_CHANNELS*32.
- PRESCALE_MIN, 3, prescale values below this are clamped up to it (matches PCA9685 hardware minimum).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- register_led_i  input  [0:511]  LED parameter bus.
  - Channel n occupies bits 32n..32n+31, bytes in the order ON_L, ON_H, OFF_L, OFF_H.
  - Each byte is MSB-first, so bit 32n is ON_L bit7.
- prescale_i  input  8  PRE_SCALE register value.
- tick_i  input  1  base oscillator tick enable (one clk_i-wide pulse per 25 MHz-equivalent tick).
- sleep_i  input  1  MODE1.SLEEP.
- invrt_i  input  1  MODE2.INVRT.
- pwm_o  output  NUM_CHANNELS  PWM outputs; bit n is channel n.
- count_o  output  12  current period counter value.
- period_start_o  output  1  one-cycle pulse when the counter wraps to 0.

Behaviour:
- Reset (async, rst_i=1), all registered:
  - prescaler counter = 0 and count_o = 0.
  - all shadow registers = 0.
  - pwm_o = {NUM_CHANNELS{invrt_i}}; the outputs are logically off, with invert applied.
  - period_start_o = 0.
- Field decode for channel n:
  - ON = {ON_H[3:0], ON_L}, FULL_ON = ON_H[4].
  - OFF = {OFF_H[3:0], OFF_L}, FULL_OFF = OFF_H[4].
  - Bits [7:5] of ON_H and OFF_H are ignored.
- Prescaler:
  - eff_pre = max(prescale_i, PRESCALE_MIN).
  - On each tick_i, the prescaler increments. When it equals eff_pre, it resets to 0 and the period counter advances by 1.
  - The counter advances once per (eff_pre+1) ticks.
  - prescale_i is sampled continuously; a change takes effect from the next prescaler compare.
- Period counter:
  - 12-bit; 4095 wraps to 0.
  - On the clock edge where it wraps, period_start_o=1 for that cycle only, and every channel's shadow (ON, OFF, FULL_ON, FULL_OFF) loads from register_led_i in the same edge.
  - Count 0 therefore already uses the new values.
  - register_led_i changes at any other time are ignored until the next wrap.
- Channel level, raw_n, computed from count_o and the shadow values:
  - FULL_OFF=1 -> 0. This has priority over FULL_ON.
  - else FULL_ON=1 -> 1.
  - else ON==OFF -> 0.
  - else ON<OFF -> 1 when ON <= count < OFF.
  - else (ON>OFF, wrapping pulse) -> 1 when count >= ON or count < OFF.
- Output:
  - pwm_o[n] is registered: pwm_o[n] at edge k+1 = raw_n(count_o at cycle k) XOR invrt_i. Latency is 1 clk_i.
  - invrt_i applies in all modes, including sleep and reset.
- Sleep, sleep_i=1:
  - prescaler and counter are held at 0; no period_start_o.
  - raw_n is forced to 0, so pwm_o = {invrt_i}.
  - Shadows load from register_led_i every cycle while asleep.
  - On deassertion, counting resumes from count 0 / prescaler 0 with the values loaded during sleep. No period_start_o is emitted for this restart.
- tick_i=0: all counters hold; outputs keep being recomputed from the current count.
- Simultaneous events: sleep_i dominates tick_i. The wrap-edge shadow load and tick handling occur in the same edge without conflict.

Test Plan:
- Ch0 50% duty:
  - Stimulus: reset; prescale_i=3, tick_i=1, ch0 ON=0x000, OFF=0x800; wait one wrap.
  - Required: pwm_o[0]=1 for 2048*4 = 8192 cycles, then 0 for 8192 cycles. Period is 16384 cycles; period_start_o pulses every 16384 cycles.
- Wrapping pulse with clamping:
  - Stimulus: ch1 ON=4000, OFF=100; prescale_i=0.
  - Required: prescale is clamped to 3. pwm_o[1] is high for counts 4000..4095 and 0..99 (196 counts = 784 cycles) and low otherwise.
- Full on/off priority:
  - Stimulus: ch2 ON_H=0x10 gives constant pwm_o[2]=1. Then set ch2 OFF_H=0x10 as well.
  - Required: after the next wrap, pwm_o[2]=0 constantly. ON==OFF=0x123 with no full bits gives constant 0.
- Mid-period update:
  - Stimulus: at count 1000, change ch0 OFF from 0x800 to 0x400.
  - Required: the current period still falls at 2048; the next period falls at 1024. A falling edge is observed one cycle after count_o reaches the compare value.
- Sleep and invert:
  - Stimulus: assert sleep_i at count 2000 with invrt_i=1.
  - Required: count_o=0 and pwm_o=0xFFFF while asleep. After release, count_o restarts from 0, with no period_start_o at the restart.
- Reset mid-operation:
  - Stimulus: pulse rst_i at count 3000 with invrt_i=0.
  - Required: count_o=0 and pwm_o=0 immediately (asynchronous, before the next clock edge). Shadows are 0, so outputs stay 0 until the first wrap loads new values.
